// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
//   Front-panel button event scheduler. Each debounced button runs a
//   press / long-press / auto-repeat machine; the resulting events park in
//   a one-deep slot per button and a round-robin arbiter moves them onto a
//   single valid/ready event stream.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   enable        event generation enable (0 flushes FSMs and slots)
//   btn_state     debounced button levels, 1 = pressed
//   evt_valid     event available on evt_btn / evt_type
//   evt_ready     consumer accepts when evt_valid & evt_ready
//   evt_btn       index of the button that produced the event
//   evt_type      00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   overflow      sticky: an event was dropped because its slot was full
//   clr_overflow  clears overflow (a same-edge drop wins)
module btn_event_ctrl #(
  parameter int               BTN_W         = 2,
  parameter int               CNT_W         = 24,
  parameter logic [CNT_W-1:0] LONG_CYCLES   = 24'd5_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd1_000_000,
  localparam int              N_BTN         = 2**BTN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [BTN_W-1:0] evt_btn,
  output logic [1:0]       evt_type,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_CYCLES - 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] prev_q;

  logic [N_BTN-1:0] raise;
  logic [1:0]       raise_type [N_BTN];

  logic [N_BTN-1:0] slot_vld_q;
  logic [N_BTN-1:0] slot_vld_d;
  logic [1:0]       slot_type_q [N_BTN];
  logic [1:0]       slot_type_d [N_BTN];
  logic             drop;

  logic [BTN_W-1:0] rr_q;
  logic             out_free;
  logic             grant_vld;
  logic [BTN_W-1:0] grant_idx;
  logic [BTN_W-1:0] scan_idx;

  // Per-button event machines. Release is checked first so it beats a
  // LONG/REPEAT that would fall on the same edge.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      raise[i]      = 1'b0;
      raise_type[i] = EVT_PRESS;
      if (!enable) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (btn_state[i] && !prev_q[i]) begin
              raise[i]      = 1'b1;
              raise_type[i] = EVT_PRESS;
              state_d[i]    = S_PRESSED;
              cnt_d[i]      = '0;
            end
          end
          S_PRESSED: begin
            if (!btn_state[i]) begin
              raise[i]      = 1'b1;
              raise_type[i] = EVT_RELEASE;
              state_d[i]    = S_IDLE;
              cnt_d[i]      = '0;
            end else if (cnt_q[i] == LONG_LAST) begin
              raise[i]      = 1'b1;
              raise_type[i] = EVT_LONG;
              state_d[i]    = S_HELD;
              cnt_d[i]      = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          S_HELD: begin
            if (!btn_state[i]) begin
              raise[i]      = 1'b1;
              raise_type[i] = EVT_RELEASE;
              state_d[i]    = S_IDLE;
              cnt_d[i]      = '0;
            end else if (REPEAT_CYCLES != '0) begin
              if (cnt_q[i] == REP_LAST) begin
                raise[i]      = 1'b1;
                raise_type[i] = EVT_REPEAT;
                cnt_d[i]      = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Round-robin scan starting just above the last grant; the index wraps
  // naturally in BTN_W bits, and the final step revisits rr itself.
  always_comb begin
    out_free  = !evt_valid || evt_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      scan_idx = rr_q + k[BTN_W-1:0];
      if (enable && out_free && !grant_vld && slot_vld_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Slot update: a grant frees the slot on the same edge, so a new event
  // only overflows when the slot stays occupied.
  always_comb begin
    drop = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      slot_vld_d[i]  = slot_vld_q[i];
      slot_type_d[i] = slot_type_q[i];
      if (grant_vld && (grant_idx == i[BTN_W-1:0])) begin
        slot_vld_d[i] = 1'b0;
      end
      if (raise[i]) begin
        if (slot_vld_d[i]) begin
          drop = 1'b1;
        end else begin
          slot_vld_d[i]  = 1'b1;
          slot_type_d[i] = raise_type[i];
        end
      end
      if (!enable) begin
        slot_vld_d[i] = 1'b0;
      end
    end
  end

  // ---- stage boundary: FSM, slot, arbiter and output registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      prev_q     <= '0;
      slot_vld_q <= '0;
      rr_q       <= '1;
      evt_valid  <= 1'b0;
      evt_btn    <= '0;
      evt_type   <= EVT_PRESS;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      prev_q     <= enable ? btn_state : '0;
      slot_vld_q <= slot_vld_d;
      if (grant_vld) begin
        evt_valid <= 1'b1;
        evt_btn   <= grant_idx;
        evt_type  <= slot_type_q[grant_idx];
        rr_q      <= grant_idx;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Slot payload carries no reset; it is only meaningful with its valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      slot_type_q[i] <= slot_type_d[i];
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl
//   Bench for btn_event_ctrl with LONG_CYCLES=10, REPEAT_CYCLES=4.
//   A behavioural model tracks each button by the edge it was pressed on
//   and derives LONG/REPEAT from elapsed edges; directed scenarios pin the
//   model with literal event timings, then a random phase runs.
module tb_btn_event_ctrl;

  localparam int N    = 4;
  localparam int LONG = 10;
  localparam int REP  = 4;

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_LONG    = 2'b10;
  localparam logic [1:0] T_REPEAT  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] btn_state;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_btn;
  logic [1:0]   evt_type;
  logic         overflow;
  logic         clr_overflow;

  int total = 0;
  int bad   = 0;

  btn_event_ctrl #(
    .BTN_W(2), .CNT_W(24), .LONG_CYCLES(24'd10), .REPEAT_CYCLES(24'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .btn_state(btn_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
    .evt_type(evt_type), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int         c;
    int         b;
    logic [1:0] t;
  } ev_t;

  ev_t        log_q[$];
  int         cyc = 0;
  bit         m_pressed [N];
  int         m_t0      [N];
  bit         m_slot_v  [N];
  logic [1:0] m_slot_t  [N];
  int         m_rr;
  bit         m_out_v;
  int         m_out_btn;
  logic [1:0] m_out_t;
  bit         m_ov;

  always @(posedge clk) begin : model
    int         e;
    int         g;
    bit         fr;
    bit         dr;
    bit         r  [N];
    logic [1:0] rt [N];
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int b = 0; b < N; b++) begin
        m_pressed[b] = 0;
        m_t0[b]      = 0;
        m_slot_v[b]  = 0;
        m_slot_t[b]  = 2'b00;
      end
      m_rr      = N - 1;
      m_out_v   = 0;
      m_out_btn = 0;
      m_out_t   = 2'b00;
      m_ov      = 0;
    end else begin
      for (int b = 0; b < N; b++) begin
        r[b]  = 0;
        rt[b] = T_PRESS;
        if (!enable) begin
          m_pressed[b] = 0;
        end else if (m_pressed[b] && !btn_state[b]) begin
          r[b] = 1; rt[b] = T_RELEASE; m_pressed[b] = 0;
        end else if (m_pressed[b]) begin
          e = cyc - m_t0[b];
          if (e == LONG) begin
            r[b] = 1; rt[b] = T_LONG;
          end else if (REP != 0 && e > LONG && ((e - LONG) % REP) == 0) begin
            r[b] = 1; rt[b] = T_REPEAT;
          end
        end else if (btn_state[b]) begin
          r[b] = 1; rt[b] = T_PRESS; m_pressed[b] = 1; m_t0[b] = cyc;
        end
      end
      fr = !m_out_v || evt_ready;
      g  = -1;
      if (enable && fr) begin
        for (int i = 1; i <= N; i++) begin
          if (g < 0 && m_slot_v[(m_rr + i) % N]) g = (m_rr + i) % N;
        end
      end
      if (g >= 0) begin
        m_out_v   = 1;
        m_out_btn = g;
        m_out_t   = m_slot_t[g];
        m_slot_v[g] = 0;
        m_rr      = g;
        log_q.push_back('{cyc, g, m_slot_t[g]});
      end else if (evt_ready) begin
        m_out_v = 0;
      end
      dr = 0;
      for (int b = 0; b < N; b++) begin
        if (!enable) begin
          m_slot_v[b] = 0;
        end else if (r[b]) begin
          if (m_slot_v[b]) dr = 1;
          else begin
            m_slot_v[b] = 1;
            m_slot_t[b] = rt[b];
          end
        end
      end
      if (dr) m_ov = 1;
      else if (clr_overflow) m_ov = 0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_ev(input string nm, input int idx, input int c, input int b,
                        input logic [1:0] t);
    if (idx < log_q.size()) begin
      chk({nm, "_cyc"}, log_q[idx].c, c);
      chk({nm, "_btn"}, log_q[idx].b, b);
      chk({nm, "_typ"}, {30'd0, log_q[idx].t}, {30'd0, t});
    end else begin
      chk({nm, "_present"}, log_q.size(), idx + 1);
    end
  endtask

  always @(negedge clk) begin
    chk("evt_valid", {31'd0, evt_valid}, {31'd0, m_out_v});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ov});
    if (m_out_v) begin
      chk("evt_btn", {30'd0, evt_btn}, m_out_btn);
      chk("evt_type", {30'd0, evt_type}, {30'd0, m_out_t});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int base;
    int nslot;
    rst_n = 1'b0; enable = 1'b1; btn_state = '0; evt_ready = 1'b1; clr_overflow = 1'b0;
    tick(2);
    chk("rst_valid", {31'd0, evt_valid}, 0);
    chk("rst_btn", {30'd0, evt_btn}, 0);
    chk("rst_type", {30'd0, evt_type}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    rst_n = 1'b1;
    tick(2);

    // Press button 2 for 20 edges: PRESS, LONG, two REPEATs, RELEASE.
    base = log_q.size();
    btn_state = 4'b0100; k = cyc + 1;
    tick(20);
    btn_state = 4'b0000;
    tick(5);
    chk("s1_count", log_q.size() - base, 5);
    chk_ev("s1_press", base + 0, k + 1, 2, T_PRESS);
    chk_ev("s1_long", base + 1, k + 11, 2, T_LONG);
    chk_ev("s1_rep1", base + 2, k + 15, 2, T_REPEAT);
    chk_ev("s1_rep2", base + 3, k + 19, 2, T_REPEAT);
    chk_ev("s1_rel", base + 4, k + 21, 2, T_RELEASE);
    chk("s1_ovf", {31'd0, overflow}, 0);

    // Round robin from reset pointer: order 0,1,3.
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    base = log_q.size();
    btn_state = 4'b1011; k = cyc + 1;
    tick(6);
    btn_state = 4'b0000;
    tick(10);
    chk_ev("rr_a0", base + 0, k + 1, 0, T_PRESS);
    chk_ev("rr_a1", base + 1, k + 2, 1, T_PRESS);
    chk_ev("rr_a2", base + 2, k + 3, 3, T_PRESS);
    // Leave rr at 1, then the same press gives 3,0,1.
    btn_state = 4'b0010; tick(3); btn_state = 4'b0000; tick(4);
    base = log_q.size();
    btn_state = 4'b1011; k = cyc + 1;
    tick(6);
    btn_state = 4'b0000;
    tick(10);
    chk_ev("rr_b0", base + 0, k + 1, 3, T_PRESS);
    chk_ev("rr_b1", base + 1, k + 2, 0, T_PRESS);
    chk_ev("rr_b2", base + 2, k + 3, 1, T_PRESS);

    // Backpressure, drop and overflow clear.
    evt_ready = 1'b0;
    btn_state = 4'b0010; tick(3);
    btn_state = 4'b0000; tick(3);
    chk("bp_valid", {31'd0, evt_valid}, 1);
    chk("bp_btn", {30'd0, evt_btn}, 1);
    chk("bp_type", {30'd0, evt_type}, T_PRESS);
    chk("bp_ovf0", {31'd0, overflow}, 0);
    btn_state = 4'b0010; tick(2);
    chk("bp_ovf1", {31'd0, overflow}, 1);
    chk("bp_hold", {30'd0, evt_type}, T_PRESS);
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    chk("bp_clr", {31'd0, overflow}, 0);
    evt_ready = 1'b1; btn_state = 4'b0000;
    tick(8);

    // Disable with button 0 held.
    btn_state = 4'b0001; tick(4);
    enable = 1'b0;
    base = log_q.size();
    tick(5);
    chk("dis_noevt", log_q.size() - base, 0);
    chk("dis_valid", {31'd0, evt_valid}, 0);
    nslot = 0;
    for (int b = 0; b < N; b++) nslot += int'(m_slot_v[b]);
    chk("dis_slots", nslot, 0);
    enable = 1'b1; k = cyc + 1;
    tick(3);
    chk_ev("dis_press", base, k + 1, 0, T_PRESS);
    btn_state = 4'b0000; tick(4);

    // Reset while an event is stalled and button 2 is HELD.
    evt_ready = 1'b0;
    btn_state = 4'b0100; tick(13);
    chk("rm_valid_pre", {31'd0, evt_valid}, 1);
    rst_n = 1'b0; tick(1);
    chk("rm_valid", {31'd0, evt_valid}, 0);
    chk("rm_btn", {30'd0, evt_btn}, 0);
    chk("rm_type", {30'd0, evt_type}, 0);
    chk("rm_ovf", {31'd0, overflow}, 0);
    rst_n = 1'b1; evt_ready = 1'b1;
    base = log_q.size(); k = cyc + 1;
    tick(3);
    chk_ev("rm_press", base, k + 1, 2, T_PRESS);
    btn_state = 4'b0000; tick(4);

    // Release exactly on the LONG edge: RELEASE only.
    base = log_q.size();
    btn_state = 4'b1000; k = cyc + 1;
    tick(10);
    btn_state = 4'b0000;
    tick(5);
    chk("col_count", log_q.size() - base, 2);
    chk_ev("col_press", base + 0, k + 1, 3, T_PRESS);
    chk_ev("col_rel", base + 1, k + 11, 3, T_RELEASE);

    // Random phase, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) btn_state[b] = ~btn_state[b];
      end
      evt_ready    = ($urandom_range(0, 3) != 0);
      enable       = ($urandom_range(0, 79) != 0);
      clr_overflow = ($urandom_range(0, 39) == 0);
      rst_n        = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    rst_n = 1'b1; enable = 1'b1; clr_overflow = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
